barrett_mulmod: RTL and testbench

Pipelined modular multiplier computing p = a·b mod Q (Kyber/ML-KEM, Q = 3329) with a fixed 3-cycle latency, a valid flag and an aligned sideband tag. It sits in PE0 directly upstream of the butterfly add/sub stage. The companion operand path runs through a `delay_n` line of DEPTH = 3, so that operand arrives in the same cycle as this block's product. A global enable stalls the whole pipeline in lock-step with the delay line.

---
 rtl/barrett_mulmod.sv | 144 ++++++++++++++
 tb/tb_barrett_mulmod.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/barrett_mulmod.sv
// Purpose : 3-stage pipelined modular multiplier p = a*b mod Q (ML-KEM, Q = 3329),
//           using Barrett reduction, with a valid flag and an aligned sideband tag.
//           This file also holds delay_n, the matching operand delay line.
// Ports   : clk, rst (sync, active-low), en_i (global stall), valid_i/a_i/b_i/tag_i in,
//           valid_o/p_o/tag_o out.
// Latency : 3 enabled cycles. No backpressure other than en_i, which freezes every stage.

// ---------------------------------------------------------------------------
// delay_n
// Purpose : DEPTH-stage register delay line. It carries companion operands so
//           they arrive in the same cycle as the multiplier product.
// Ports   : clk, rst (sync, active-low), en_i (hold when 0), d_i in, d_o out.
// Latency : DEPTH enabled cycles. en_i = 0 holds every stage.
// ---------------------------------------------------------------------------
module delay_n #(
  parameter int W     = 12,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] d_o
);

  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (en_i) begin
      r_pipe[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign d_o = r_pipe[DEPTH-1];

endmodule

// ---------------------------------------------------------------------------
// barrett_mulmod
// Purpose : p = (a*b) mod Q. Stage 1 multiplies. Stage 2 estimates the
//           quotient. Stage 3 subtracts it and applies one conditional
//           correction.
// Ports   : clk, rst, en_i, valid_i, a_i, b_i, tag_i -> valid_o, p_o, tag_o
// Latency : 3 enabled cycles and 1 result per enabled cycle. Data registers
//           load whenever en_i = 1, whatever the valid bit says.
// ---------------------------------------------------------------------------
module barrett_mulmod #(
  parameter int DWIDTH    = 12,
  parameter int Q         = 3329,
  parameter int BARRETT_K = 24,
  parameter int BARRETT_M = 5039,
  parameter int TAGW      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic [DWIDTH-1:0] a_i,
  input  logic [DWIDTH-1:0] b_i,
  input  logic [TAGW-1:0]   tag_i,
  output logic              valid_o,
  output logic [DWIDTH-1:0] p_o,
  output logic [TAGW-1:0]   tag_o
);

  localparam int LATENCY = 3;
  localparam int PW      = 2 * DWIDTH;                    // full product width (24)
  localparam int MW      = PW + $clog2(BARRETT_M + 1);    // prod * M width (37)
  // The quotient estimate needs 13 bits, not 12. For operands up to 4095,
  // the true quotient 4095^2 / 3329 is about 5037, so a 12-bit estimate
  // would wrap and corrupt the remainder.
  localparam int TW      = MW - BARRETT_K;
  // The remainder before correction is below 2Q (6658), so 14 bits are
  // enough. The subtraction is done modulo 2^14 on the low bits only.
  localparam int RW      = DWIDTH + 2;

  // Valid and tag travel in LATENCY-deep shift registers alongside the data stages.
  logic              r_vld [LATENCY];
  logic [TAGW-1:0]   r_tag [LATENCY];

  logic [PW-1:0]     r_prod1;
  logic [PW-1:0]     r_prod2;
  logic [TW-1:0]     r_t2;
  logic [DWIDTH-1:0] r_p;

  logic [PW-1:0]     w_prod;
  logic [MW-1:0]     w_mul;
  logic [TW-1:0]     w_t;
  logic [RW-1:0]     w_tq;
  logic [RW-1:0]     w_r;
  logic [RW-1:0]     w_rc;
  logic [DWIDTH-1:0] w_p;

  // S1: full unsigned product.
  assign w_prod = {{DWIDTH{1'b0}}, a_i} * {{DWIDTH{1'b0}}, b_i};

  // S2: quotient estimate floor(prod * M / 2^K).
  // The estimate is never above the true quotient and at most one below it,
  // so one correction step is enough.
  assign w_mul = MW'(r_prod1) * MW'(BARRETT_M);
  assign w_t   = TW'(w_mul >> BARRETT_K);

  // S3: remainder and single conditional subtraction.
  assign w_tq = RW'(r_t2) * RW'(Q);
  assign w_r  = RW'(r_prod2) - w_tq;
  assign w_rc = (w_r >= RW'(Q)) ? (w_r - RW'(Q)) : w_r;
  assign w_p  = DWIDTH'(w_rc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_tag[i] <= '0;
      end
      r_prod1 <= '0;
      r_prod2 <= '0;
      r_t2    <= '0;
      r_p     <= '0;
    end else if (en_i) begin
      r_vld[0] <= valid_i;
      r_tag[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_tag[i] <= r_tag[i-1];
      end
      r_prod1 <= w_prod;
      r_prod2 <= r_prod1;
      r_t2    <= w_t;
      r_p     <= w_p;
    end
  end

  assign valid_o = r_vld[LATENCY-1];
  assign tag_o   = r_tag[LATENCY-1];
  assign p_o     = r_p;

endmodule

// File: tb/tb_barrett_mulmod.sv
module tb_barrett_mulmod;

  localparam int DW = 12;
  localparam int TW = 4;
  localparam int QM = 3329;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          valid_o;
  logic [DW-1:0] p_o;
  logic [TW-1:0] tag_o;
  logic [DW-1:0] dly_a;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic          v;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
  } smp_t;

  // Inputs accepted at recent enabled edges, oldest first. The result of
  // hist[0] is due once three entries are present.
  smp_t hist[$];

  barrett_mulmod dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .p_o     (p_o),
    .tag_o   (tag_o)
  );

  delay_n #(.W(DW), .DEPTH(3)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .en_i (en_i),
    .d_i  (a_i),
    .d_o  (dly_a)
  );

  always #5 clk = ~clk;

  function automatic int ref_mod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (int'(a) * int'(b)) % QM;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", name, obs, exp);
    end
  endtask

  // One clock edge. Update the reference from the inputs seen at the edge,
  // then compare every output against it.
  task automatic tick();
    smp_t s;
    smp_t e;
    logic pre_rst;
    logic pre_en;
    s.v = valid_i;
    s.a = a_i;
    s.b = b_i;
    s.tag = tag_i;
    pre_rst = rst;
    pre_en = en_i;
    @(posedge clk);
    #1;
    if (!pre_rst) begin
      hist.delete();
    end else if (pre_en) begin
      hist.push_back(s);
      if (hist.size() > 3) e = hist.pop_front();
    end
    if (hist.size() < 3) begin
      check("empty_vld", {31'd0, valid_o}, 32'd0);
      check("empty_p", {20'd0, p_o}, 32'd0);
      check("empty_tag", {28'd0, tag_o}, 32'd0);
    end else begin
      e = hist[0];
      check("model_vld", {31'd0, valid_o}, {31'd0, e.v});
      check("model_p", {20'd0, p_o}, ref_mod(e.a, e.b));
      check("model_tag", {28'd0, tag_o}, {28'd0, e.tag});
      check("align_a", {20'd0, dly_a}, {20'd0, e.a});
      if (valid_o) check("p_below_q", {31'd0, (int'(p_o) < QM)}, 32'd1);
    end
  endtask

  task automatic drive(input logic v, input int a, input int b, input int t);
    valid_i = v;
    a_i = DW'(a);
    b_i = DW'(b);
    tag_i = TW'(t);
  endtask

  int a_tab[4] = '{3328, 17, 2, 4095};
  int b_tab[4] = '{3328, 17, 1665, 4095};
  int p_tab[4] = '{1, 289, 1, 852};

  initial begin
    // Reset held for two edges with a valid op presented.
    rst = 1'b0;
    en_i = 1'b1;
    drive(1'b1, 5, 5, 3);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_vld", {31'd0, valid_o}, 32'd0);
      check("rst_p", {20'd0, p_o}, 32'd0);
      check("rst_tag", {28'd0, tag_o}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post_rst_vld", {31'd0, valid_o}, 32'd0);
    end
    tick();
    check("first_vld", {31'd0, valid_o}, 32'd1);
    check("first_p", {20'd0, p_o}, 32'd25);

    // Directed vectors back-to-back with tags 1..4.
    for (int j = 0; j < 6; j++) begin
      if (j < 4) drive(1'b1, a_tab[j], b_tab[j], j + 1);
      else drive(1'b0, 0, 0, 0);
      tick();
      if (j >= 2) begin
        check("dir_vld", {31'd0, valid_o}, 32'd1);
        check("dir_p", {20'd0, p_o}, p_tab[j-2]);
        check("dir_tag", {28'd0, tag_o}, j - 1);
      end
    end

    // Stall: the op enters S1, en_i drops for 5 cycles, then resumes.
    drive(1'b0, 0, 0, 0);
    tick();
    tick();
    drive(1'b1, 100, 200, 7);
    tick();
    en_i = 1'b0;
    drive(1'b1, 11, 13, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_vld", {31'd0, valid_o}, 32'd0);
    end
    en_i = 1'b1;
    drive(1'b0, 0, 0, 0);
    tick();
    check("resume1_vld", {31'd0, valid_o}, 32'd0);
    tick();
    check("resume2_vld", {31'd0, valid_o}, 32'd1);
    check("resume2_p", {20'd0, p_o}, 32'd26);
    check("resume2_tag", {28'd0, tag_o}, 32'd7);
    tick();
    check("resume3_vld", {31'd0, valid_o}, 32'd0);

    // Reset mid-stream: three ops, reset after the second, and none come out.
    drive(1'b1, 1000, 1000, 1);
    tick();
    drive(1'b1, 2000, 3, 2);
    tick();
    rst = 1'b0;
    drive(1'b1, 4000, 4000, 3);
    tick();
    rst = 1'b1;
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_vld", {31'd0, valid_o}, 32'd0);
    end
    drive(1'b1, 9, 10, 5);
    tick();
    drive(1'b0, 0, 0, 0);
    tick();
    tick();
    check("postrst_vld", {31'd0, valid_o}, 32'd1);
    check("postrst_p", {20'd0, p_o}, 32'd90);
    check("postrst_tag", {28'd0, tag_o}, 32'd5);

    // Random traffic with en_i high about 80% of the time.
    for (int i = 0; i < 2000; i++) begin
      en_i = ($urandom_range(0, 9) < 8);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)));
      tick();
    end
    en_i = 1'b1;
    drive(1'b0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
